// File: rtl/spatz_pkg.sv
// Shared VRF types for the Spatz vector unit: register/bank addressing, word
// and byte-enable widths, and the write-port bundle seen by the VRF write arbiter.
package spatz_pkg;

    localparam int unsigned NrVRFBanks      = 4;
    localparam int unsigned NrVRFWritePorts = 3;
    localparam int unsigned NrVRegs         = 32;
    localparam int unsigned VRFWordWidth    = 64;
    localparam int unsigned VRFWordBWidth   = VRFWordWidth / 8;
    localparam int unsigned VRegIdxWidth    = $clog2(NrVRegs);
    localparam int unsigned BankIdxWidth    = $clog2(NrVRFBanks);

    typedef logic [VRegIdxWidth-1:0]  vreg_t;
    typedef logic [BankIdxWidth-1:0]  vrf_bank_t;
    typedef logic [VRFWordWidth-1:0]  vreg_data_t;
    typedef logic [VRFWordBWidth-1:0] vreg_be_t;

    typedef struct packed {
        vreg_t     vreg;
        vrf_bank_t bank;
    } vreg_addr_t;

    typedef enum logic [1:0] {
        VFU_VD_WD   = 2'd0,
        VLSU_VD_WD  = 2'd1,
        VSLDU_VD_WD = 2'd2
    } vreg_port_wd_e;

    typedef struct packed {
        vreg_addr_t addr;
        vreg_data_t data;
        vreg_be_t   be;
    } vrf_wr_req_t;

endpackage

// File: rtl/spatz_bank_rr_arb.sv
// Round-robin arbiter for one VRF bank: one-hot grant among requesting ports,
// pointer advances past the winner and holds when nothing is granted.
module spatz_bank_rr_arb #(
    parameter int unsigned NrPorts = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrPorts-1:0] req_i,
    output logic [NrPorts-1:0] gnt_c_o
);

    localparam int unsigned PtrWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    logic [PtrWidth-1:0] ptr_q, ptr_d;

    // First requester at or after the pointer wins.
    always_comb begin
        logic        found;
        int unsigned idx;
        gnt_c_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            idx = (32'(ptr_q) + i) % NrPorts;
            for (int unsigned p = 0; p < NrPorts; p++) begin
                if (!found && (p == idx) && req_i[p]) begin
                    found      = 1'b1;
                    gnt_c_o[p] = 1'b1;
                    ptr_d      = PtrWidth'((p + 1) % NrPorts);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spatz_vrf_wr_arbiter.sv
// VRF write arbiter: routes VFU/VLSU/VSLDU writes to the banked VRF, one write
// per bank per cycle, with registered bank writes and per-port done pulses.
module spatz_vrf_wr_arbiter
    import spatz_pkg::*;
#(
    parameter int unsigned NrWrPorts = NrVRFWritePorts,
    parameter int unsigned NrBanks   = NrVRFBanks
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NrWrPorts-1:0] req_valid_i,
    output logic [NrWrPorts-1:0] req_ready_o,
    input  vreg_addr_t           req_addr_i   [NrWrPorts],
    input  vreg_data_t           req_data_i   [NrWrPorts],
    input  vreg_be_t             req_be_i     [NrWrPorts],
    output logic [NrBanks-1:0]   bank_we_o,
    output vreg_t                bank_vreg_o  [NrBanks],
    output vreg_data_t           bank_wdata_o [NrBanks],
    output vreg_be_t             bank_wbe_o   [NrBanks],
    output logic [NrWrPorts-1:0] wr_done_o
);

    vrf_wr_req_t            req      [NrWrPorts];
    logic [NrWrPorts-1:0]   bank_req [NrBanks];
    logic [NrWrPorts-1:0]   bank_gnt [NrBanks];
    vrf_wr_req_t            win      [NrBanks];

    logic [NrBanks-1:0]     we_q;
    vreg_t                  vreg_q   [NrBanks];
    vreg_data_t             wdata_q  [NrBanks];
    vreg_be_t               wbe_q    [NrBanks];
    logic [NrWrPorts-1:0]   done_q;

    // Bank decode; requests are masked during reset so nothing is granted.
    always_comb begin
        for (int unsigned p = 0; p < NrWrPorts; p++) begin
            req[p] = '{addr: req_addr_i[p], data: req_data_i[p], be: req_be_i[p]};
        end
        for (int unsigned b = 0; b < NrBanks; b++) begin
            bank_req[b] = '0;
            for (int unsigned p = 0; p < NrWrPorts; p++) begin
                bank_req[b][p] = req_valid_i[p] & ~rst_i
                               & (32'(req_addr_i[p].bank) == b);
            end
        end
    end

    for (genvar gb = 0; gb < NrBanks; gb++) begin : gen_bank_arb
        spatz_bank_rr_arb #(
            .NrPorts (NrWrPorts)
        ) i_bank_arb (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .req_i   (bank_req[gb]),
            .gnt_c_o (bank_gnt[gb])
        );
    end

    // Fold grants back per port and select each bank's winning payload.
    always_comb begin
        req_ready_o = '0;
        for (int unsigned b = 0; b < NrBanks; b++) begin
            req_ready_o = req_ready_o | bank_gnt[b];
            win[b]      = '0;
            for (int unsigned p = 0; p < NrWrPorts; p++) begin
                if (bank_gnt[b][p]) begin
                    win[b] = req[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q   <= '0;
            done_q <= '0;
            for (int unsigned b = 0; b < NrBanks; b++) begin
                vreg_q[b]  <= '0;
                wdata_q[b] <= '0;
                wbe_q[b]   <= '0;
            end
        end else begin
            done_q <= req_ready_o;
            for (int unsigned b = 0; b < NrBanks; b++) begin
                we_q[b] <= |bank_gnt[b];
                if (|bank_gnt[b]) begin
                    vreg_q[b]  <= win[b].addr.vreg;
                    wdata_q[b] <= win[b].data;
                    wbe_q[b]   <= win[b].be;
                end
            end
        end
    end

    assign bank_we_o    = we_q;
    assign bank_vreg_o  = vreg_q;
    assign bank_wdata_o = wdata_q;
    assign bank_wbe_o   = wbe_q;
    assign wr_done_o    = done_q;

endmodule
